// File: rtl/cavlc_zeros_run_packer_p.sv
// Packs one CAVLC total_zeros codeword and its run_before codewords into an
// MSB-aligned window; the finished block is held until downstream takes it.
module cavlc_zeros_run_packer_p #(
   parameter int ZC_W  = 9,
   parameter int RC_W  = 11,
   parameter int ACC_W = 32,
   parameter int LEN_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             zeros_valid,
   input  logic [ZC_W-1:0]  zeros_bit,
   input  logic [3:0]       zeros_len,
   input  logic             zeros_last,
   input  logic             run_valid,
   input  logic [RC_W-1:0]  run_bit,
   input  logic [3:0]       run_len,
   input  logic             run_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_bit,
   output logic [LEN_W-1:0] out_len,
   output logic             out_ovf
);

   localparam int LW1 = LEN_W + 1;
   localparam int LW2 = LEN_W + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [LEN_W-1:0]   r_len;
   logic               r_ovf;
   logic               r_out_valid;
   logic               r_in_ready;

   logic [LEN_W:0]     w_zlen;
   logic [LEN_W:0]     w_rlen;
   logic [ACC_W-1:0]   w_zmask;
   logic [ACC_W-1:0]   w_rmask;
   logic [ACC_W-1:0]   w_zbits;
   logic [ACC_W-1:0]   w_rbits;
   logic [LEN_W:0]     w_zsh;
   logic [LEN_W+1:0]   w_rsh;
   logic [ACC_W-1:0]   w_zload;
   logic [2*ACC_W-1:0] w_wide;
   logic [LEN_W:0]     w_sum;
   logic               w_sat;

   function automatic logic [LEN_W:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
      logic [3:0] v;
      v = (len > max_len) ? max_len : len;
      return {{(LEN_W-3){1'b0}}, v};
   endfunction

   assign w_zlen  = clamp_len(zeros_len, 4'(ZC_W));
   assign w_rlen  = clamp_len(run_len, 4'(RC_W));
   assign w_zmask = ~({ACC_W{1'b1}} << w_zlen);
   assign w_rmask = ~({ACC_W{1'b1}} << w_rlen);
   assign w_zbits = {{(ACC_W-ZC_W){1'b0}}, zeros_bit} & w_zmask;
   assign w_rbits = {{(ACC_W-RC_W){1'b0}}, run_bit} & w_rmask;
   assign w_zsh   = LW1'(ACC_W) - w_zlen;
   assign w_zload = w_zbits << w_zsh;

   // Run is placed in a double-width window so bits past ACC_W fall off the bottom.
   assign w_rsh   = LW2'(2*ACC_W) - {2'b00, r_len} - {1'b0, w_rlen};
   assign w_wide  = {{ACC_W{1'b0}}, w_rbits} << w_rsh;
   assign w_sum   = {1'b0, r_len} + w_rlen;
   assign w_sat   = (w_sum > LW1'(ACC_W));

   // Block FSM with accumulator, length, overflow and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= {ACC_W{1'b0}};
         r_len       <= {LEN_W{1'b0}};
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (zeros_valid) begin
                  r_acc <= w_zload;
                  r_len <= w_zlen[LEN_W-1:0];
                  r_ovf <= 1'b0;
                  if (zeros_last) begin
                     r_state     <= HOLD;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                  end else begin
                     r_state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (run_valid) begin
                  r_acc <= r_acc | w_wide[2*ACC_W-1:ACC_W];
                  if (w_sat) begin
                     r_len <= LEN_W'(ACC_W);
                     r_ovf <= 1'b1;
                  end else begin
                     r_len <= w_sum[LEN_W-1:0];
                  end
                  if (run_last) begin
                     r_state     <= HOLD;
                     r_out_valid <= 1'b1;
                     r_in_ready  <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_bit   = r_acc;
   assign out_len   = r_len;
   assign out_ovf   = r_ovf;

endmodule
